// File: rtl/ysyx_210978_div_unit.sv
// -----------------------------------------------------------------------------
// ysyx_210978_div_unit
//
// RV64M divide front-end between the EX stage and the iterative 64-bit divider
// core. It decodes DIV/DIVU/REM/REMU and their W forms, prepares the operands,
// answers divide-by-zero and signed overflow locally, and otherwise starts the
// core. It captures the core's one-cycle result, selects the quotient or the
// remainder, sign-extends W results, and holds the result until it is taken.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   flush               pipeline kill: drops the current and any pending op
//   in_valid/in_ready   request handshake from EX
//   funct3, is_word     op select (100 DIV, 101 DIVU, 110 REM, 111 REMU), W form
//   src1, src2          dividend / divisor as read from the register file
//   out_valid/out_ready result handshake towards writeback
//   result              selected, extended result
//   div_in_valid        one-cycle start pulse to the core
//   div_divw/div_signed latched op flavour for the core
//   div_dividend/div_divisor prepared operands for the core
//   div_flush           copy of flush (the core does not abort on it)
//   div_out_ready       core idle
//   div_out_valid       core result strobe (one cycle)
//   div_quotient/div_remainder core results, valid with div_out_valid
// -----------------------------------------------------------------------------
module ysyx_210978_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            div_in_valid,
    output logic            div_divw,
    output logic            div_signed,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    output logic            div_flush,
    input  logic            div_out_ready,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } state_t;

    // Most-negative values as they look after operand preparation: the 64-bit
    // one, and the 32-bit one after sign extension.
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    // W results are always the sign extension of the low word, even for
    // DIVUW/REMUW.
    function automatic logic [XLEN-1:0] fit_word(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    state_t          state_reg;
    logic            out_valid_reg;
    logic [XLEN-1:0] result_reg;
    logic            div_in_valid_reg;
    logic            op_word_reg;
    logic            op_signed_reg;
    logic            op_rem_reg;
    logic [XLEN-1:0] dividend_reg;
    logic [XLEN-1:0] divisor_reg;

    logic            in_signed;
    logic [XLEN-1:0] prep_a;
    logic [XLEN-1:0] prep_b;
    logic            div_zero;
    logic            sgn_ovf;
    logic            special;
    logic [XLEN-1:0] special_sel;
    logic            accept;
    logic [XLEN-1:0] core_sel;

    // funct3[2] is always 1 for this unit; decode only needs bits [1:0].
    logic unused_funct3;
    assign unused_funct3 = funct3[2];

    assign in_ready = (state_reg == S_IDLE) & div_out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        in_signed = ~funct3[0];
        if (is_word) begin
            prep_a = in_signed ? {{(XLEN-32){src1[31]}}, src1[31:0]} : {{(XLEN-32){1'b0}}, src1[31:0]};
            prep_b = in_signed ? {{(XLEN-32){src2[31]}}, src2[31:0]} : {{(XLEN-32){1'b0}}, src2[31:0]};
        end else begin
            prep_a = src1;
            prep_b = src2;
        end
        div_zero = (prep_b == '0);
        sgn_ovf  = in_signed && (prep_b == '1) && (prep_a == (is_word ? MIN_W : MIN_X));
        special  = div_zero | sgn_ovf;
        // Divide by zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
        if (funct3[1]) begin
            special_sel = div_zero ? prep_a : '0;
        end else begin
            special_sel = div_zero ? '1 : prep_a;
        end
        core_sel = op_rem_reg ? div_remainder : div_quotient;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            out_valid_reg    <= 1'b0;
            result_reg       <= '0;
            div_in_valid_reg <= 1'b0;
            op_word_reg      <= 1'b0;
            op_signed_reg    <= 1'b0;
            op_rem_reg       <= 1'b0;
            dividend_reg     <= '0;
            divisor_reg      <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_word_reg   <= is_word;
                        op_signed_reg <= in_signed;
                        op_rem_reg    <= funct3[1];
                        dividend_reg  <= prep_a;
                        divisor_reg   <= prep_b;
                        if (special) begin
                            result_reg    <= fit_word(special_sel, is_word);
                            out_valid_reg <= 1'b1;
                            state_reg     <= S_HOLD;
                        end else begin
                            div_in_valid_reg <= 1'b1;
                            state_reg        <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // The pulse goes out even when flushed: the core has
                    // already latched the op, so its answer must be drained.
                    div_in_valid_reg <= 1'b0;
                    state_reg        <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (div_out_valid) begin
                        if (flush) begin
                            // The core is finishing right now; nothing left
                            // to drain, just drop the answer.
                            state_reg <= S_IDLE;
                        end else begin
                            result_reg    <= fit_word(core_sel, op_word_reg);
                            out_valid_reg <= 1'b1;
                            state_reg     <= S_HOLD;
                        end
                    end else if (flush) begin
                        state_reg <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (div_out_valid) begin
                        state_reg <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (flush || out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid    = out_valid_reg;
    assign result       = result_reg;
    assign div_in_valid = div_in_valid_reg;
    assign div_divw     = op_word_reg;
    assign div_signed   = op_signed_reg;
    assign div_dividend = dividend_reg;
    assign div_divisor  = divisor_reg;
    assign div_flush    = flush;

endmodule

// File: tb/tb_ysyx_210978_div_unit.sv
// -----------------------------------------------------------------------------
// Testbench for ysyx_210978_div_unit. Includes a behavioural model of the
// divider core, a scoreboard fed at accept time from an RV64M reference model,
// and a monitor that pops and compares whenever a result is taken.
// -----------------------------------------------------------------------------
module tb_ysyx_210978_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = 3'b100;
    logic        is_word = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        div_in_valid;
    logic        div_divw;
    logic        div_signed;
    logic [63:0] div_dividend;
    logic [63:0] div_divisor;
    logic        div_flush;
    logic        div_out_ready = 1'b1;
    logic        div_out_valid = 1'b0;
    logic [63:0] div_quotient = '0;
    logic [63:0] div_remainder = '0;

    ysyx_210978_div_unit dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .is_word(is_word), .src1(src1), .src2(src2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .div_in_valid(div_in_valid), .div_divw(div_divw), .div_signed(div_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_flush(div_flush),
        .div_out_ready(div_out_ready), .div_out_valid(div_out_valid),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] res;
        bit          special;
        int          starts;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   starts = 0;
    int   force_lat = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // RISC-V division rules on 64-bit values, via magnitudes so that the
    // most-negative / -1 case falls out of plain unsigned arithmetic.
    function automatic void divrem(input logic [63:0] a, input logic [63:0] b, input bit sgn,
                                   output logic [63:0] q, output logic [63:0] r);
        logic [63:0] ua, ub, qm, rm;
        bit sa, sb_;
        if (b == 64'd0) begin
            q = '1;
            r = a;
        end else begin
            sa  = sgn && a[63];
            sb_ = sgn && b[63];
            ua  = sa ? -a : a;
            ub  = sb_ ? -b : b;
            qm  = ua / ub;
            rm  = ua % ub;
            q   = (sa ^ sb_) ? -qm : qm;
            r   = sa ? -rm : rm;
        end
    endfunction

    function automatic logic [63:0] ref_result(input bit [2:0] f3, input bit w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [63:0] x, y, q, r, sel;
        bit sgn;
        sgn = !f3[0];
        if (w) begin
            x = sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
            y = sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
        end else begin
            x = a;
            y = b;
        end
        divrem(x, y, sgn, q, r);
        sel = f3[1] ? r : q;
        return w ? {{32{sel[31]}}, sel[31:0]} : sel;
    endfunction

    function automatic bit is_special(input bit [2:0] f3, input bit w,
                                      input logic [63:0] a, input logic [63:0] b);
        bit sgn;
        sgn = !f3[0];
        if (w)
            return (b[31:0] == 32'd0) || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) || (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    // Divider core model: latches on the start pulse, answers after 1..4
    // cycles (or force_lat) with a single-cycle strobe.
    initial begin : core_model
        logic [63:0] q, r;
        int lat;
        forever begin
            @(posedge clock); #1;
            if (!reset && div_in_valid) begin
                starts++;
                divrem(div_dividend, div_divisor, div_signed, q, r);
                div_out_ready = 1'b0;
                lat = (force_lat != 0) ? force_lat : $urandom_range(1, 4);
                @(posedge clock); #1;
                check("start_pulse_width", {63'd0, div_in_valid}, 64'd0);
                repeat (lat - 1) begin
                    @(posedge clock); #1;
                end
                div_out_valid = 1'b1;
                div_quotient  = q;
                div_remainder = r;
                div_out_ready = 1'b1;
                @(posedge clock); #1;
                div_out_valid = 1'b0;
                div_quotient  = {$urandom, $urandom};
                div_remainder = {$urandom, $urandom};
            end
        end
    end

    initial begin : ready_noise
        forever begin
            @(posedge clock); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency, core-start count and hold stability on each new
    // result; scoreboard compare when the result is taken.
    bit          ov_prev = 1'b0, taken_prev = 1'b0, dov_prev = 1'b0, acc_prev = 1'b0;
    logic [63:0] held = '0;
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            ov_prev = 1'b0; taken_prev = 1'b0; dov_prev = 1'b0; acc_prev = 1'b0;
        end else begin
            if (out_valid) begin
                if (!ov_prev || taken_prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
                    end else begin
                        e = sb[0];
                        check({e.name, "_latency"}, {63'd0, e.special ? acc_prev : dov_prev}, 64'd1);
                        check({e.name, "_core_starts"}, starts, e.special ? e.starts : e.starts + 1);
                    end
                end else begin
                    check("hold_stable", result, held);
                end
                if (out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check(e.name, result, e.res);
                    $display("txn %-28s result=%h expected=%h", e.name, result, e.res);
                end
            end
            ov_prev    = out_valid;
            taken_prev = out_valid && out_ready;
            held       = result;
            dov_prev   = div_out_valid;
            acc_prev   = in_valid && in_ready && !flush;
        end
    end

    task automatic do_op(input string name, input bit [2:0] f3, input bit w,
                         input logic [63:0] a, input logic [63:0] b, input bit keep);
        exp_t e;
        int n;
        @(posedge clock); #1;
        funct3 = f3; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!(in_ready && !flush) && n < 300) begin
            n++;
            @(negedge clock);
        end
        if (n >= 300) begin
            check({name, "_accept_timeout"}, {63'd0, in_ready}, 64'd1);
        end else if (keep) begin
            e.res = ref_result(f3, w, a, b);
            e.special = is_special(f3, w, a, b);
            e.starts = starts;
            e.name = name;
            sb.push_back(e);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        src1 = {$urandom, $urandom};
        src2 = {$urandom, $urandom};
        funct3 = 3'(4 + $urandom_range(0, 3));
        is_word = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) check("drain_timeout", sb.size(), 64'd0);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h0000_0000_8000_0000;
            4: return 64'h0000_0000_FFFF_FFFF;
            5: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        repeat (3) @(negedge clock);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_div_in_valid", {63'd0, div_in_valid}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;

        do_op("divu_100_7", 3'b101, 1'b0, 64'd100, 64'd7, 1'b1);
        do_op("remu_100_7", 3'b111, 1'b0, 64'd100, 64'd7, 1'b1);
        do_op("div_m7_2", 3'b100, 1'b0, -64'sd7, 64'd2, 1'b1);
        do_op("rem_m7_2", 3'b110, 1'b0, -64'sd7, 64'd2, 1'b1);
        do_op("divu_5_0", 3'b101, 1'b0, 64'd5, 64'd0, 1'b1);
        do_op("rem_5_0", 3'b110, 1'b0, 64'd5, 64'd0, 1'b1);
        do_op("div_min_m1", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b1);
        do_op("rem_min_m1", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b1);
        do_op("divw_min_m1", 3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1);
        do_op("divuw_ffffffff_1", 3'b101, 1'b1, 64'hFFFF_FFFF, 64'd1, 1'b1);
        do_op("remuw_x_0", 3'b111, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hABCD_0000_0000_0000, 1'b1);
        wait_drain();

        // Flush while the core is working; its answer must be swallowed.
        force_lat = 6;
        do_op("flushed_divu", 3'b101, 1'b0, 64'd100, 64'd7, 1'b0);
        @(posedge clock); #1;
        flush = 1'b1;
        @(negedge clock);
        check("div_flush_copy", {63'd0, div_flush}, 64'd1);
        @(posedge clock); #1;
        flush = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            check("in_ready_during_drain", {63'd0, in_ready}, 64'd0);
            n++;
        end while (!div_out_valid && n < 20);
        if (!div_out_valid) check("drain_strobe_timeout", {63'd0, div_out_valid}, 64'd1);
        @(negedge clock);
        check("in_ready_after_drain", {63'd0, in_ready}, 64'd1);
        force_lat = 0;
        do_op("divu_9_3_after_flush", 3'b101, 1'b0, 64'd9, 64'd3, 1'b1);
        wait_drain();

        // flush together with in_valid must block the accept.
        @(posedge clock); #1;
        funct3 = 3'b101; is_word = 1'b0; src1 = 64'd5; src2 = 64'd0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clock);
        check("no_out_after_blocked_accept", {63'd0, out_valid}, 64'd0);

        // flush in HOLD drops the held result.
        out_ready = 1'b0;
        do_op("hold_flush_divu_5_0", 3'b101, 1'b0, 64'd5, 64'd0, 1'b1);
        @(negedge clock);
        check("hold_flush_out_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
        @(negedge clock);
        check("out_valid_after_hold_flush", {63'd0, out_valid}, 64'd0);

        // Result held five cycles with out_ready low, taken on the sixth.
        do_op("hold_divu_100_7", 3'b101, 1'b0, 64'd100, 64'd7, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("hold_out_valid_seen", {63'd0, out_valid}, 64'd1);
        check("in_ready_in_hold", {63'd0, in_ready}, 64'd0);
        repeat (4) @(negedge clock);
        check("hold_out_valid_cycle5", {63'd0, out_valid}, 64'd1);
        @(posedge clock); #1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        @(negedge clock);
        check("in_ready_after_take", {63'd0, in_ready}, 64'd1);
        check("out_valid_after_take", {63'd0, out_valid}, 64'd0);

        // Randomized ops with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [63:0] a, b;
            bit [2:0] f3;
            bit w;
            a  = pick();
            b  = pick();
            f3 = 3'(4 + $urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            do_op($sformatf("rnd%0d_f%0d_w%0d", i, f3, w), f3, w, a, b, 1'b1);
        end
        rand_ready = 1'b0;
        @(posedge clock); #1;
        out_ready = 1'b1;
        wait_drain();
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
